// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_controller: RV32I fetch/decode/exec/mem/wb sequencing FSM     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic [2:0]  imm_type,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [31:0] retired,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    state_t      r_state;
    logic [31:0] r_retired;

    logic [6:0] w_opcode;
    logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic       w_is_load, w_is_store, w_is_opimm, w_is_op;
    logic       w_legal, w_retire;
    logic       w_unused_instr;

    assign w_opcode    = instr[6:0];
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_opimm  = (w_opcode == c_OP_IMM);
    assign w_is_op     = (w_opcode == c_OP_OP);
    assign w_legal     = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                         w_is_load | w_is_store | w_is_opimm | w_is_op;
    assign w_unused_instr = &{1'b0, instr[31:7]};

    // Retire on the edge that leaves the last state of an instruction.
    assign w_retire = ((r_state == S_EXEC) && (w_is_branch | w_is_jal | w_is_jalr)) ||
                      ((r_state == S_MEM) && mem_ready && w_is_store) ||
                      (r_state == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= 32'd0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    if (w_is_branch | w_is_jal | w_is_jalr) begin
                        r_state <= S_FETCH;
                    end else if (w_is_load | w_is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM:    if (mem_ready) r_state <= w_is_store ? S_FETCH : S_WB;
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imm_type = 3'b001;
        if (w_is_lui | w_is_auipc) begin
            imm_type = 3'b100;
        end else if (w_is_jal) begin
            imm_type = 3'b000;
        end else if (w_is_store) begin
            imm_type = 3'b010;
        end else if (w_is_branch) begin
            imm_type = 3'b011;
        end
    end

    // Enables are held at zero for the whole reset window, even mid-cycle.
    always_comb begin
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        illegal      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = w_is_auipc | w_is_jal | w_is_branch;
                    alu_src_b = ~(w_is_op | w_is_branch);
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                    end else if (w_is_jal | w_is_jalr) begin
                        pc_write  = 1'b1;
                        pc_src    = w_is_jal ? 2'd1 : 2'd2;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = w_is_store;
                    if (mem_ready && w_is_store) begin
                        pc_write = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = w_is_load ? 2'd1 : 2'd0;
                    pc_write  = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the immediate generator's type select from the instruction register, and produces the per-cycle enables for the PC, IR, register file, ALU operand muxes and the shared instruction/data memory port. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- none; widths are fixed for RV32I.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  current instruction register contents
- mem_ready  in  1  memory completes the pending access this cycle
- branch_taken  in  1  ALU branch-compare result, valid in EXEC
- state  out  3  current FSM state encoding
- imm_type  out  3  immediate select: 000 J, 001 I, 010 S, 011 B, 100 U
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- retired  out  32  retired-instruction count
- illegal  out  1  high while in TRAP

## Operation
State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7. Only `state` and `retired` are registered; every other output is combinational from `state`, `instr[6:0]` and the inputs.

Opcode classes (`instr[6:0]`) and their `imm_type`:
- LUI 0110111 → U.
- AUIPC 0010111 → U.
- JAL 1101111 → J.
- JALR 1100111 → I.
- BRANCH 1100011 → B.
- LOAD 0000011 → I.
- STORE 0100011 → S.
- OP-IMM 0010011 → I.
- OP 0110011 → I; the value is don't-care.
- Any other opcode → `imm_type` = 001 and the instruction is illegal.

`imm_type` is decoded from `instr` continuously in every state.

State behaviour:
- FETCH: `mem_req` = 1, `mem_addr_sel` = 0, `mem_we` = 0. Stay until `mem_ready` = 1. On the ready cycle assert `ir_write` and go to DECODE.
- DECODE: no enables asserted. If the opcode is illegal, go to TRAP; otherwise go to EXEC.
- EXEC:
  - `alu_src_a` = 1 for AUIPC, JAL and BRANCH; otherwise 0.
  - `alu_src_b` = 0 for OP and BRANCH; otherwise 1.
  - BRANCH: `pc_write` = 1, `pc_src` = 1 if `branch_taken` else 0; go to FETCH and retire.
  - JAL and JALR: `pc_write` = 1, `pc_src` = 1 for JAL or 2 for JALR, `reg_write` = 1, `wb_sel` = 2; go to FETCH and retire.
  - LOAD and STORE: go to MEM.
  - All others: go to WB.
- MEM: `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = 1 for STORE. Stay until `mem_ready` = 1. On the ready cycle:
  - STORE: `pc_write` = 1, `pc_src` = 0; go to FETCH and retire.
  - LOAD: go to WB.
- WB:
  - `reg_write` = 1.
  - `wb_sel` = 1 for LOAD, otherwise 0; LUI relies on the ALU passing the immediate through.
  - `pc_write` = 1, `pc_src` = 0.
  - Go to FETCH and retire.
- TRAP: all enables 0, `mem_req` = 0, `illegal` = 1. TRAP is absorbing; only `rst` leaves it.

Retire counter:
- "Retire" means `retired` increments by 1 on that clock edge.
- It wraps from 0xFFFF_FFFF to 0.
- Illegal instructions never retire.

## Timing
- Reset values: `state` = FETCH, `retired` = 0.
- While `rst` = 1, every combinational output is forced to 0, including `mem_req`. `imm_type` still follows `instr`.
- Reset asserted mid-instruction (including during a pending memory access) aborts immediately. The access is dropped and no retire occurs.
- Latency with zero memory wait (`mem_ready` high on the first request cycle):
  - BRANCH, JAL, JALR: 3 cycles.
  - ALU ops, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle that `mem_ready` is low in FETCH or MEM adds one cycle.
- `mem_req` remains high and its address/write controls remain stable until the edge at which `mem_ready` is sampled high.
- `mem_ready` is ignored whenever `mem_req` = 0.
- `pc_write`, `reg_write` and `ir_write` are each asserted for exactly one cycle per instruction at most. They never assert in DECODE or TRAP.

## Test plan
- Reset, then ADDI (`0x00500093`) with `mem_ready` tied high:
  - state sequence 0,1,2,4,0;
  - `imm_type` = 001;
  - `reg_write` and `pc_write` high in WB only;
  - `retired` = 1 after 4 cycles.
- LW (`0x0000A103`) with `mem_ready` low for 2 cycles in MEM:
  - `mem_addr_sel` = 1 and `mem_we` = 0 held for 3 MEM cycles;
  - then WB with `wb_sel` = 1;
  - total 7 cycles.
- BEQ (`0x00208463`):
  - with `branch_taken` = 1: EXEC gives `pc_src` = 1, `pc_write` = 1, `imm_type` = 011;
  - repeat with `branch_taken` = 0: `pc_src` = 0;
  - each instruction takes 3 cycles.
- JAL (`0x008000EF`): EXEC shows `imm_type` = 000, `pc_src` = 1, `reg_write` = 1, `wb_sel` = 2. JALR shows `pc_src` = 2, `imm_type` = 001.
- Illegal opcode `0x0000007F`:
  - DECODE goes to TRAP;
  - `illegal` = 1 and `mem_req` = 0 for 10 further cycles;
  - `retired` unchanged;
  - then assert `rst`: state returns to FETCH, `illegal` = 0.
- SW (`0x0020A023`) with `rst` pulsed during MEM:
  - `mem_req` drops asynchronously;
  - `retired` = 0;
  - after release, state = FETCH.
